// File: rtl/status_buffer_pkg.sv
// Shared NoC types: flit format, router ports and VC status states.
// Imported by the input-buffer slice and its FIFO.
package params_noc;

   localparam int VC_NUM         = 2;
   localparam int VC_SIZE        = $clog2(VC_NUM);
   localparam int FLIT_DATA_SIZE = 16;

   typedef enum logic [2:0] {
      LOCAL,
      NORTH,
      SOUTH,
      WEST,
      EAST
   } port_t;

   typedef enum logic [1:0] {
      HEAD,
      BODY,
      TAIL,
      HEADTAIL
   } flit_label_t;

   typedef struct packed {
      flit_label_t               flit_label;
      logic [VC_SIZE-1:0]        vc_id;
      logic [FLIT_DATA_SIZE-1:0] data;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE,
      VA,
      ACTIVE
   } vc_state_t;

   function automatic logic is_head(input flit_label_t l);
      return (l == HEAD) || (l == HEADTAIL);
   endfunction

   function automatic logic is_tail(input flit_label_t l);
      return (l == TAIL) || (l == HEADTAIL);
   endfunction

endpackage

// File: rtl/status_buffer_circular_fifo.sv
// Circular flit store with wrap-around pointers and an occupancy count.
// push/pop arrive already qualified by the owning buffer.
module circular_fifo
   import params_noc::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  flit_t                  wdata,
   output flit_t                  rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   flit_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   // Depth is a power of two, so pointer overflow is the wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: rtl/status_buffer.sv
// Per-VC input buffer of a router port: flit FIFO, VC status machine
// (IDLE -> VA -> ACTIVE) and on/off back-pressure to the upstream router.
module status_buffer
   import params_noc::*;
#(
   parameter int BUFFER_SIZE   = 8,
   parameter int OFF_THRESHOLD = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               write_i,
   input  logic               read_i,
   input  flit_t              input_Data,
   input  port_t              port_i,
   input  logic [VC_SIZE-1:0] vc_New,
   input  logic               vc_Val,
   output flit_t              output_Data,
   output logic               buf_empty,
   output logic               buf_full,
   output logic               buf_On_Off,
   output port_t              port_o,
   output logic               vc_Req,
   output logic               vc_Alloc,
   output logic               switch_Req,
   output logic [VC_SIZE-1:0] downstream_Vc,
   output logic               err
);

   localparam int CW = $clog2(BUFFER_SIZE) + 1;

   vc_state_t     state;
   vc_state_t     state_nxt;
   flit_t         front;
   logic [CW-1:0] count;
   logic          read_ok;
   logic          drop;
   logic          push;
   logic          pop;
   logic          load_port;
   logic          load_vc;
   logic          err_nxt;

   circular_fifo #(
      .DEPTH (BUFFER_SIZE)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (input_Data),
      .rdata (front),
      .count (count),
      .empty (buf_empty),
      .full  (buf_full)
   );

   assign read_ok = read_i && !buf_empty && (state == ACTIVE);
   // A full buffer still takes a flit when a switch read frees a slot.
   assign push    = write_i && (!buf_full || read_ok);
   assign pop     = read_ok || drop;

   assign err_nxt = (write_i && buf_full && !read_ok)
                  || (read_i && !read_ok)
                  || drop;

   always_comb begin
      state_nxt = state;
      drop      = 1'b0;
      load_port = 1'b0;
      load_vc   = 1'b0;
      case (state)
         IDLE: begin
            if (!buf_empty) begin
               if (is_head(front.flit_label)) begin
                  load_port = 1'b1;
                  state_nxt = VA;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         VA: begin
            if (vc_Val) begin
               load_vc   = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (read_ok && is_tail(front.flit_label))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         port_o        <= LOCAL;
         downstream_Vc <= '0;
         err           <= 1'b0;
      end else begin
         state <= state_nxt;
         err   <= err_nxt;
         if (load_port) port_o        <= port_i;
         if (load_vc)   downstream_Vc <= vc_New;
      end
   end

   assign vc_Req     = (state == VA);
   assign vc_Alloc   = (state == ACTIVE);
   assign switch_Req = vc_Alloc && !buf_empty;
   assign buf_On_Off =
      (CW'(BUFFER_SIZE) - count) > CW'(OFF_THRESHOLD);

   always_comb begin
      output_Data       = front;
      output_Data.vc_id = downstream_Vc;
   end

endmodule

// File: tb/tb_status_buffer.sv
// Scoreboard bench for status_buffer: flow, VC handshake, fill, errors.
module tb_status_buffer;
   import params_noc::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               write_i;
   logic               read_i;
   flit_t              input_Data;
   port_t              port_i;
   logic [VC_SIZE-1:0] vc_New;
   logic               vc_Val;
   flit_t              output_Data;
   logic               buf_empty;
   logic               buf_full;
   logic               buf_On_Off;
   port_t              port_o;
   logic               vc_Req;
   logic               vc_Alloc;
   logic               switch_Req;
   logic [VC_SIZE-1:0] downstream_Vc;
   logic               err;

   int    n_checks = 0;
   int    n_fail   = 0;
   flit_t sb_q[$];

   status_buffer #(
      .BUFFER_SIZE   (8),
      .OFF_THRESHOLD (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .write_i       (write_i),
      .read_i        (read_i),
      .input_Data    (input_Data),
      .port_i        (port_i),
      .vc_New        (vc_New),
      .vc_Val        (vc_Val),
      .output_Data   (output_Data),
      .buf_empty     (buf_empty),
      .buf_full      (buf_full),
      .buf_On_Off    (buf_On_Off),
      .port_o        (port_o),
      .vc_Req        (vc_Req),
      .vc_Alloc      (vc_Alloc),
      .switch_Req    (switch_Req),
      .downstream_Vc (downstream_Vc),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic flit_t mk(input flit_label_t l,
                                input logic [VC_SIZE-1:0] v,
                                input logic [15:0] d);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = v;
      f.data       = d;
      return f;
   endfunction

   // Upstream vc_id is inverted so the downstream overwrite is visible.
   task automatic wr(input flit_label_t l, input logic [15:0] d,
                     input logic [VC_SIZE-1:0] exp_vc);
      input_Data = mk(l, ~exp_vc, d);
      write_i    = 1'b1;
      sb_q.push_back(mk(l, exp_vc, d));
      tick();
      write_i = 1'b0;
   endtask

   task automatic sb_compare(input string tag);
      if (sb_q.size() > 0)
         check(tag, 32'(output_Data), 32'(sb_q.pop_front()));
      else
         check({tag, "_sb_avail"}, 32'(sb_q.size()), 32'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_empty"},  32'(buf_empty),     32'd1);
      check({pfx, "_full"},   32'(buf_full),      32'd0);
      check({pfx, "_onoff"},  32'(buf_On_Off),    32'd1);
      check({pfx, "_vcreq"},  32'(vc_Req),        32'd0);
      check({pfx, "_alloc"},  32'(vc_Alloc),      32'd0);
      check({pfx, "_swreq"},  32'(switch_Req),    32'd0);
      check({pfx, "_err"},    32'(err),           32'd0);
      check({pfx, "_port"},   32'(port_o),        32'(LOCAL));
      check({pfx, "_dvc"},    32'(downstream_Vc), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      write_i    = 1'b0;
      read_i     = 1'b0;
      input_Data = '0;
      port_i     = LOCAL;
      vc_New     = '0;
      vc_Val     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_outputs("rst");

      // Head routed EAST, grant delayed three cycles
      port_i = EAST;
      wr(HEAD, 16'hA000, 1'b1);
      check("hd_vcreq_early", 32'(vc_Req), 32'd0);
      check("hd_nonempty", 32'(buf_empty), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("va_vcreq", 32'(vc_Req), 32'd1);
      end
      check("va_port", 32'(port_o), 32'(EAST));
      vc_New = 1'b1;
      vc_Val = 1'b1;
      tick();
      vc_Val = 1'b0;
      port_i = LOCAL;
      check("gr_vcreq", 32'(vc_Req), 32'd0);
      check("gr_alloc", 32'(vc_Alloc), 32'd1);
      check("gr_swreq", 32'(switch_Req), 32'd1);
      check("gr_dvc", 32'(downstream_Vc), 32'd1);
      check("gr_vcid", 32'(output_Data.vc_id), 32'd1);
      check("gr_port", 32'(port_o), 32'(EAST));

      // Rest of the packet, then back-to-back reads
      wr(BODY, 16'hA001, 1'b1);
      wr(BODY, 16'hA002, 1'b1);
      wr(TAIL, 16'hA003, 1'b1);
      read_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb_compare("pkt_flit");
         tick();
      end
      read_i = 1'b0;
      check("pkt_empty", 32'(buf_empty), 32'd1);
      check("pkt_swreq", 32'(switch_Req), 32'd0);
      check("pkt_idle", 32'(vc_Alloc), 32'd0);
      check("pkt_err", 32'(err), 32'd0);

      // Fill to full with the head waiting in VA
      port_i = SOUTH;
      wr(HEAD, 16'hB000, 1'b0);
      check("fill_onoff", 32'(buf_On_Off), 32'd1);
      for (int i = 2; i <= 8; i++) begin
         wr(BODY, 16'(16'hB000 + i), 1'b0);
         check("fill_onoff", 32'(buf_On_Off), (i <= 5) ? 32'd1 : 32'd0);
      end
      check("fill_full", 32'(buf_full), 32'd1);
      check("fill_vcreq", 32'(vc_Req), 32'd1);
      check("fill_port", 32'(port_o), 32'(SOUTH));
      input_Data = mk(BODY, 1'b1, 16'hDEAD);
      write_i = 1'b1;
      tick();
      write_i = 1'b0;
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_full", 32'(buf_full), 32'd1);
      tick();
      check("ovf_err_clr", 32'(err), 32'd0);
      vc_New = 1'b0;
      vc_Val = 1'b1;
      tick();
      vc_Val = 1'b0;
      check("fill_alloc", 32'(vc_Alloc), 32'd1);
      check("fill_dvc", 32'(downstream_Vc), 32'd0);

      // Read and write together while full
      sb_compare("rw_front");
      input_Data = mk(TAIL, 1'b1, 16'hB0FF);
      sb_q.push_back(mk(TAIL, 1'b0, 16'hB0FF));
      read_i  = 1'b1;
      write_i = 1'b1;
      tick();
      read_i  = 1'b0;
      write_i = 1'b0;
      check("rw_full", 32'(buf_full), 32'd1);
      check("rw_err", 32'(err), 32'd0);
      read_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sb_compare("drain_flit");
         tick();
      end
      read_i = 1'b0;
      check("drain_empty", 32'(buf_empty), 32'd1);
      check("drain_idle", 32'(vc_Alloc), 32'd0);
      check("drain_onoff", 32'(buf_On_Off), 32'd1);

      // Protocol errors
      read_i = 1'b1;
      tick();
      read_i = 1'b0;
      check("rd_empty_err", 32'(err), 32'd1);
      check("rd_empty_cnt", 32'(buf_empty), 32'd1);
      tick();
      check("rd_empty_clr", 32'(err), 32'd0);

      input_Data = mk(BODY, 1'b0, 16'hC001);
      write_i = 1'b1;
      tick();
      write_i = 1'b0;
      check("orph_present", 32'(buf_empty), 32'd0);
      check("orph_err_pre", 32'(err), 32'd0);
      tick();
      check("orph_err", 32'(err), 32'd1);
      check("orph_dropped", 32'(buf_empty), 32'd1);
      check("orph_state", 32'(vc_Req), 32'd0);
      tick();
      check("orph_clr", 32'(err), 32'd0);

      port_i = NORTH;
      wr(HEAD, 16'hD000, 1'b1);
      tick();
      check("va2_vcreq", 32'(vc_Req), 32'd1);
      read_i = 1'b1;
      tick();
      read_i = 1'b0;
      check("rd_va_err", 32'(err), 32'd1);
      check("rd_va_kept", 32'(buf_empty), 32'd0);
      check("rd_va_front", 32'(output_Data.data), 32'hD000);
      tick();
      check("rd_va_clr", 32'(err), 32'd0);
      vc_New = 1'b1;
      vc_Val = 1'b1;
      tick();
      vc_Val = 1'b0;
      wr(BODY, 16'hD001, 1'b1);
      check("mid_alloc", 32'(vc_Alloc), 32'd1);
      check("mid_port", 32'(port_o), 32'(NORTH));

      // Reset in the middle of an active packet
      rst_n = 1'b0;
      tick();
      check_reset_outputs("mid_rst");
      rst_n = 1'b1;
      sb_q.delete();
      tick();
      check("post_rst_idle", 32'(vc_Req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/status_buffer.md
Name: status_buffer

Overview:
- Per-virtual-channel input buffer of a NoC router input port.
- Holds flits in a circular FIFO of BUFFER_SIZE entries and runs the VC status machine: IDLE -> VA (virtual-channel allocation) -> ACTIVE (switch allocation / flit transfer).
- Latches the routed output port and the granted downstream VC per packet.
- Provides on/off flow-control back-pressure to the upstream router.

Parameters:
- BUFFER_SIZE, 8, FIFO depth in flits; power of two, at least 4.
- OFF_THRESHOLD, 2, buf_On_Off deasserts when free slots are at or below this value; must be less than BUFFER_SIZE.

Ports:
- clk  in  1  system clock; everything is clocked on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- write_i  in  1  write input_Data this cycle.
- read_i  in  1  pop the front flit (switch grant).
- input_Data  in  flit_t  incoming flit.
- port_i  in  port_t  route-computation result for the front head flit.
- vc_New  in  VC_SIZE  downstream VC granted by the VC allocator.
- vc_Val  in  1  vc_New is valid (grant strobe).
- output_Data  out  flit_t  front flit, with vc_id replaced by downstream_Vc.
- buf_empty  out  1  FIFO empty.
- buf_full  out  1  FIFO full.
- buf_On_Off  out  1  1 = upstream may send; 0 = stop.
- port_o  out  port_t  latched output port of the current packet.
- vc_Req  out  1  VC allocation request.
- vc_Alloc  out  1  downstream VC held (state ACTIVE).
- switch_Req  out  1  switch allocation request.
- downstream_Vc  out  VC_SIZE  latched downstream VC.
- err  out  1  protocol-error pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pointers and count = 0; state = IDLE.
  - buf_empty=1, buf_full=0, buf_On_Off=1.
  - vc_Req=0, vc_Alloc=0, switch_Req=0, err=0.
  - port_o=LOCAL, downstream_Vc=0.
  - Buffer contents need not be cleared.
  - Reset mid-packet discards everything.
- FIFO:
  - Write is accepted when write_i is high and the FIFO is not full, or when it is full and a valid read happens in the same cycle.
  - Read is valid only when read_i is high, the FIFO is not empty, and state is ACTIVE.
  - Simultaneous valid read and write leaves count unchanged.
  - No same-cycle bypass: a flit written at edge t is visible on output_Data after edge t.
  - Pointers wrap modulo BUFFER_SIZE.
  - buf_empty = (count==0) and buf_full = (count==BUFFER_SIZE), both decoded combinationally from the count register.
  - buf_On_Off = (BUFFER_SIZE - count) > OFF_THRESHOLD, combinational.
- output_Data = mem[rd_ptr], with the vc_id field overwritten by downstream_Vc; content is meaningless when empty.
- State machine (Moore outputs):
  - IDLE:
    - If non-empty and the front flit label is HEAD or HEADTAIL: port_o <= port_i; next state VA.
    - If the front flit is BODY or TAIL: pop and drop it, pulse err.
  - VA:
    - vc_Req=1.
    - On vc_Val=1: downstream_Vc <= vc_New; next state ACTIVE. vc_Req is low from the next cycle.
  - ACTIVE:
    - vc_Alloc=1; switch_Req = !buf_empty.
    - A valid read of a TAIL or HEADTAIL flit returns the state to IDLE at the next edge.
- err: a registered one-cycle pulse in the cycle after any of:
  - write_i while full with no valid read (the flit is dropped);
  - read_i when empty or state is not ACTIVE (no pop);
  - non-head flit at the front in IDLE.
- Latency: a head written at edge t puts state VA after edge t+1. vc_Val sampled at edge k gives ACTIVE and switch_Req after edge k.

Decomposition:
- Package params_noc:
  - VC_NUM (2), VC_SIZE = $clog2(VC_NUM), FLIT_DATA_SIZE (16).
  - port_t enum {LOCAL, NORTH, SOUTH, WEST, EAST}.
  - flit_label_t enum {HEAD, BODY, TAIL, HEADTAIL}.
  - flit_t packed struct {flit_label, vc_id[VC_SIZE], data[FLIT_DATA_SIZE]}.
- One natural sub-module: circular_fifo (storage, pointers, count, empty/full). The status FSM stays in status_buffer.

Test Plan:
- Reset, then idle -> buf_empty=1, buf_On_Off=1, vc_Req=0, switch_Req=0, err=0, port_o=LOCAL.
- Write HEAD with port_i=EAST, then hold vc_Val=0 for 3 cycles, then vc_New=1 with vc_Val=1:
  - vc_Req=1 from the cycle after the head is in the FIFO until the grant;
  - port_o=EAST, downstream_Vc=1;
  - vc_Alloc=1 and switch_Req=1 afterwards;
  - output_Data.vc_id=1.
- Packet HEAD, BODY, BODY, TAIL read back-to-back in ACTIVE -> flits leave in order, state returns to IDLE after the TAIL read, buf_empty=1, switch_Req=0.
- Write 8 flits with no reads:
  - buf_full=1; buf_On_Off=0 once free slots <= 2 (after the 6th write);
  - a 9th write pulses err and is dropped;
  - a simultaneous read plus write when full keeps count at 8 with no err.
- Reads on an empty FIFO and in IDLE, and a BODY flit at the front in IDLE -> err pulses for one cycle each, count unchanged except the BODY flit, which is dropped.
- Assert rst_n=0 mid-packet in ACTIVE -> all outputs return to their reset values after that edge.
